emaxi_lite: RTL and testbench

- AXI4-Lite master. Converts emesh request packets into single-beat AXI reads and writes, and returns read data as emesh response packets.
- Serves as the initiator end of the slave path used by our AXI-mapped peripherals (gpio, timers). Lets on-chip emesh masters reach any AXI-Lite slave.
- One outstanding transaction at a time.

---
 rtl/emaxi_lite.sv | 142 ++++++++++++++
 tb/tb_emaxi_lite.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emaxi_lite.sv
// emaxi_lite: AXI4-Lite master turning emesh requests into single-beat AXI reads/writes
// Ports:
//   sys_clk, sys_nreset            clock, async active-low reset
//   access_in/packet_in/wait_out   emesh request side (wait_out high while busy)
//   access_out/packet_out/wait_in  emesh read-response side
//   err_irq                        sticky AXI error flag (only with EMAXI_ERR_EN)
//   m_axi_*                        AXI4-Lite master channels AW/W/B/AR/R
// Build option: define EMAXI_ERR_EN to flag bresp/rresp errors and poison read data.
module emaxi_lite #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          sys_clk,
    input  logic          sys_nreset,
    input  logic          access_in,
    input  logic [PW-1:0] packet_in,
    output logic          wait_out,
    output logic          access_out,
    output logic [PW-1:0] packet_out,
    input  logic          wait_in,
    output logic          err_irq,
    output logic [31:0]   m_axi_awaddr,
    output logic [2:0]    m_axi_awprot,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [31:0]   m_axi_wdata,
    output logic [3:0]    m_axi_wstrb,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,
    output logic [31:0]   m_axi_araddr,
    output logic [2:0]    m_axi_arprot,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [31:0]   m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RR_OUT} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] req_q, req_d, pkt_q, pkt_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [1:0]    mode, lane;
    logic [4:0]    ctrl, rsp_ctrl;
    logic [AW-1:0] dst, data, src;
    logic [3:0]    strb;
    logic [31:0]   dmask, rd_data, rsp_data;

    assign mode = req_q[2:1];
    assign ctrl = req_q[7:3];
    assign dst  = req_q[AW+7:8];
    assign data = req_q[2*AW+7:AW+8];
    assign src  = req_q[3*AW+7:2*AW+8];

    // Byte lane of the access; halves snap to an even lane, words (and mode 3) to lane 0
    assign lane  = mode == 2'd0 ? dst[1:0] : mode == 2'd1 ? {dst[1], 1'b0} : 2'd0;
    assign strb  = mode == 2'd0 ? 4'h1 : mode == 2'd1 ? 4'h3 : 4'hF;
    assign dmask = mode == 2'd0 ? 32'h0000_00FF : mode == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    assign rd_data = (m_axi_rdata >> {lane, 3'b000}) & dmask;

    assign m_axi_awaddr  = {dst[31:2], 2'b00};
    assign m_axi_araddr  = {dst[31:2], 2'b00};
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wstrb   = strb << lane;
    assign m_axi_wdata   = data << {lane, 3'b000};
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = state_q == WR_RESP;
    assign m_axi_arvalid = state_q == RD_ADDR;
    assign m_axi_rready  = state_q == RD_DATA;
    assign wait_out      = state_q != IDLE;
    assign access_out    = state_q == RR_OUT;
    assign packet_out    = pkt_q;

`ifdef EMAXI_ERR_EN
    logic err_q;
    logic rd_err;
    assign rd_err   = m_axi_rresp != 2'b00;
    assign rsp_data = rd_err ? 32'hDEAD_BEEF : rd_data;
    assign rsp_ctrl = ctrl | {rd_err, 4'b0000};
    assign err_irq  = err_q;
    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset)
            err_q <= 1'b0;
        else if ((m_axi_bvalid && state_q == WR_RESP && m_axi_bresp != 2'b00) ||
                 (m_axi_rvalid && state_q == RD_DATA && rd_err))
            err_q <= 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
    assign rsp_data    = rd_data;
    assign rsp_ctrl    = ctrl;
    assign err_irq     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        pkt_d     = pkt_q;
        // AW and W retire independently, each on its own ready
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        case (state_q)
            IDLE: if (access_in) begin
                req_d     = packet_in;
                state_d   = packet_in[0] ? WR_ADDR : RD_ADDR;
                awvalid_d = packet_in[0];
                wvalid_d  = packet_in[0];
            end
            WR_ADDR: if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_d = IDLE;
            RD_ADDR: if (m_axi_arready) state_d = RD_DATA;
            RD_DATA: if (m_axi_rvalid) begin
                pkt_d   = {{AW{1'b0}}, rsp_data, src, rsp_ctrl, mode, 1'b1};
                state_d = RR_OUT;
            end
            RR_OUT: if (!wait_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_nreset) begin
        if (!sys_nreset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pkt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pkt_q     <= pkt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end
endmodule

// File: tb/tb_emaxi_lite.sv
// tb_emaxi_lite: scoreboard-driven bench for the emaxi_lite AXI4-Lite master
module tb_emaxi_lite;
    localparam int PW = 104;

    logic          sys_clk = 1'b0;
    logic          sys_nreset, access_in, wait_out, access_out, wait_in, err_irq;
    logic [PW-1:0] packet_in, packet_out;
    logic [31:0]   m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int fails  = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int ar_cnt = 0;

    logic [31:0]   exp_aw[$];
    logic [35:0]   exp_w[$];
    logic [PW-1:0] exp_rsp[$];
    logic [31:0]   e_aw;
    logic [35:0]   e_w;
    logic [PW-1:0] e_rsp;

    emaxi_lite dut (
        .sys_clk(sys_clk), .sys_nreset(sys_nreset),
        .access_in(access_in), .packet_in(packet_in), .wait_out(wait_out),
        .access_out(access_out), .packet_out(packet_out), .wait_in(wait_in),
        .err_irq(err_irq),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after posedge, so what is seen at negedge is what the next posedge samples
    always @(negedge sys_clk) begin
        if (sys_nreset) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                checks++;
                if (exp_aw.size() == 0) begin
                    fails++;
                    $display("FAIL aw_beat unexpected: awaddr=%h", m_axi_awaddr);
                end else begin
                    e_aw = exp_aw.pop_front();
                    if (m_axi_awaddr !== e_aw) begin
                        fails++;
                        $display("FAIL aw_beat: awaddr=%h expected %h", m_axi_awaddr, e_aw);
                    end
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt++;
                checks++;
                if (exp_w.size() == 0) begin
                    fails++;
                    $display("FAIL w_beat unexpected: wstrb=%h wdata=%h", m_axi_wstrb, m_axi_wdata);
                end else begin
                    e_w = exp_w.pop_front();
                    if ({m_axi_wstrb, m_axi_wdata} !== e_w) begin
                        fails++;
                        $display("FAIL w_beat: wstrb/wdata=%h expected %h", {m_axi_wstrb, m_axi_wdata}, e_w);
                    end
                end
            end
            if (m_axi_arvalid && m_axi_arready) ar_cnt++;
            if (access_out && !wait_in) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    fails++;
                    $display("FAIL rsp unexpected: packet_out=%h", packet_out);
                end else begin
                    e_rsp = exp_rsp.pop_front();
                    if (packet_out !== e_rsp) begin
                        fails++;
                        $display("FAIL rsp_packet: packet_out=%h expected %h", packet_out, e_rsp);
                    end
                end
            end
        end
    end

    function automatic logic [PW-1:0] mkpkt(input logic w, input logic [1:0] m, input logic [4:0] c,
                                             input logic [31:0] d, input logic [31:0] dat, input logic [31:0] s);
        return {s, dat, d, c, m, w};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p);
        access_in = 1'b1;
        packet_in = p;
        tick();
        access_in = 1'b0;
    endtask

    task automatic test_reset();
        sys_nreset = 1'b1;
        access_in = 0; packet_in = '0; wait_in = 0;
        m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = '0;
        #1 sys_nreset = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             access_out, err_irq, wait_out} !== 8'b0) begin
            fails++;
            $display("FAIL reset_ctrl: valids/readies/flags=%b expected 00000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                      access_out, err_irq, wait_out});
        end
        checks++;
        if (packet_out !== '0) begin
            fails++;
            $display("FAIL reset_packet: packet_out=%h expected 0", packet_out);
        end
        checks++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_awprot, m_axi_arprot} !== '0) begin
            fails++;
            $display("FAIL reset_addr: awaddr=%h araddr=%h wdata=%h expected 0",
                     m_axi_awaddr, m_axi_araddr, m_axi_wdata);
        end
        repeat (2) @(posedge sys_clk);
        #1 sys_nreset = 1'b1;
        tick();
    endtask

    task automatic test_word_write();
        exp_aw.push_back(32'h8000_0010);
        exp_w.push_back({4'hF, 32'h1234_5678});
        send(mkpkt(1'b1, 2'd2, 5'h00, 32'h8000_0010, 32'h1234_5678, 32'h0));
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, wait_out, m_axi_awprot} !== 6'b111_000) begin
            fails++;
            $display("FAIL word_wr_issue: awvalid/wvalid/wait_out/awprot=%b expected 111000",
                     {m_axi_awvalid, m_axi_wvalid, wait_out, m_axi_awprot});
        end
        tick();
        checks++;
        if ({m_axi_bready, m_axi_awvalid, m_axi_wvalid, wait_out} !== 4'b1001) begin
            fails++;
            $display("FAIL word_wr_resp: bready/awvalid/wvalid/wait_out=%b expected 1001",
                     {m_axi_bready, m_axi_awvalid, m_axi_wvalid, wait_out});
        end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        checks++;
        if ({wait_out, m_axi_bready, access_out} !== 3'b000) begin
            fails++;
            $display("FAIL word_wr_done: wait_out/bready/access_out=%b expected 000",
                     {wait_out, m_axi_bready, access_out});
        end
    endtask

    task automatic test_byte_write();
        exp_aw.push_back(32'h8000_0010);
        exp_w.push_back({4'b1000, 32'hA500_0000});
        send(mkpkt(1'b1, 2'd0, 5'h00, 32'h8000_0013, 32'h0000_00A5, 32'h0));
        tick();
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        checks++;
        if (wait_out !== 1'b0) begin
            fails++;
            $display("FAIL byte_wr_done: wait_out=%b expected 0", wait_out);
        end
    endtask

    task automatic test_half_read();
        int ar0;
        ar0 = ar_cnt;
        exp_rsp.push_back(mkpkt(1'b1, 2'd1, 5'h0A, 32'h0040_0000, 32'h0000_BEEF, 32'h0));
        send(mkpkt(1'b0, 2'd1, 5'h0A, 32'h8000_0022, 32'h0, 32'h0040_0000));
        checks++;
        if ({m_axi_arvalid, m_axi_awvalid, access_out} !== 3'b100 || m_axi_araddr !== 32'h8000_0020) begin
            fails++;
            $display("FAIL half_rd_ar: arvalid/awvalid/access_out=%b araddr=%h expected 100 80000020",
                     {m_axi_arvalid, m_axi_awvalid, access_out}, m_axi_araddr);
        end
        tick();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hBEEF_1234;
        checks++;
        if ({m_axi_rready, m_axi_arvalid, access_out} !== 3'b100) begin
            fails++;
            $display("FAIL half_rd_r: rready/arvalid/access_out=%b expected 100",
                     {m_axi_rready, m_axi_arvalid, access_out});
        end
        tick();
        m_axi_rvalid = 1'b0;
        checks++;
        if ({access_out, m_axi_rready} !== 2'b10) begin
            fails++;
            $display("FAIL half_rd_latency: access_out/rready=%b expected 10 in 4th cycle",
                     {access_out, m_axi_rready});
        end
        tick();
        checks++;
        if ({access_out, wait_out} !== 2'b00 || ar_cnt - ar0 !== 1) begin
            fails++;
            $display("FAIL half_rd_done: access_out/wait_out=%b ar_beats=%0d expected 00 and 1",
                     {access_out, wait_out}, ar_cnt - ar0);
        end
    endtask

    task automatic test_skewed_handshake();
        int aw0, w0, ar0;
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
        exp_aw.push_back(32'h8000_0040);
        exp_w.push_back({4'hF, 32'hCAFE_F00D});
        m_axi_awready = 1'b0;
        send(mkpkt(1'b1, 2'd2, 5'h00, 32'h8000_0040, 32'hCAFE_F00D, 32'h0));
        access_in = 1'b1;
        packet_in = mkpkt(1'b0, 2'd2, 5'h00, 32'h8000_0100, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) m_axi_awready = 1'b1;
            checks++;
            if ({m_axi_awvalid, m_axi_wvalid, wait_out, m_axi_arvalid} !== 4'b1010) begin
                fails++;
                $display("FAIL skew_aw_hold[%0d]: awvalid/wvalid/wait_out/arvalid=%b expected 1010",
                         i, {m_axi_awvalid, m_axi_wvalid, wait_out, m_axi_arvalid});
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({m_axi_bready, m_axi_awvalid, wait_out, m_axi_arvalid} !== 4'b1010) begin
                fails++;
                $display("FAIL skew_b_wait[%0d]: bready/awvalid/wait_out/arvalid=%b expected 1010",
                         i, {m_axi_bready, m_axi_awvalid, wait_out, m_axi_arvalid});
            end
        end
        m_axi_bvalid = 1'b1;
        access_in = 1'b0;
        tick();
        m_axi_bvalid = 1'b0;
        checks++;
        if (wait_out !== 1'b0 || aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || ar_cnt - ar0 !== 0) begin
            fails++;
            $display("FAIL skew_beats: wait_out=%b aw=%0d w=%0d ar=%0d expected 0 1 1 0",
                     wait_out, aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] e;
        e = mkpkt(1'b1, 2'd2, 5'h05, 32'h1234_0000, 32'h1122_3344, 32'h0);
        exp_rsp.push_back(e);
        wait_in = 1'b1;
        send(mkpkt(1'b0, 2'd2, 5'h05, 32'h8000_0100, 32'h0, 32'h1234_0000));
        tick();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h1122_3344;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (access_out !== 1'b1 || packet_out !== e) begin
                fails++;
                $display("FAIL bp_hold[%0d]: access_out=%b packet_out=%h expected 1 %h",
                         i, access_out, packet_out, e);
            end
            tick();
        end
        checks++;
        if (access_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: access_out=%b expected 1", access_out);
        end
        wait_in = 1'b0;
        tick();
        checks++;
        if ({access_out, wait_out} !== 2'b00) begin
            fails++;
            $display("FAIL bp_done: access_out/wait_out=%b expected 00", {access_out, wait_out});
        end
    endtask

    task automatic test_error();
`ifdef EMAXI_ERR_EN
        exp_rsp.push_back(mkpkt(1'b1, 2'd0, 5'h13, 32'h0000_0ABC, 32'hDEAD_BEEF, 32'h0));
`else
        exp_rsp.push_back(mkpkt(1'b1, 2'd0, 5'h03, 32'h0000_0ABC, 32'h0000_00AB, 32'h0));
`endif
        send(mkpkt(1'b0, 2'd0, 5'h03, 32'h8000_0001, 32'h0, 32'h0000_0ABC));
        tick();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h0000_AB00;
        m_axi_rresp  = 2'b10;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        tick();
        checks++;
`ifdef EMAXI_ERR_EN
        if (err_irq !== 1'b1) begin
            fails++;
            $display("FAIL err_irq: err_irq=%b expected 1", err_irq);
        end
`else
        if (err_irq !== 1'b0) begin
            fails++;
            $display("FAIL err_irq: err_irq=%b expected 0", err_irq);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        exp_aw.push_back(32'h8000_0080);
        exp_w.push_back({4'hF, 32'h5555_AAAA});
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        send(mkpkt(1'b1, 2'd2, 5'h00, 32'h8000_0080, 32'h5555_AAAA, 32'h0));
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
            fails++;
            $display("FAIL midrst_pre: awvalid/wvalid=%b expected 11", {m_axi_awvalid, m_axi_wvalid});
        end
        #2 sys_nreset = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, wait_out, err_irq} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_async: awvalid/wvalid/wait_out/err_irq=%b expected 0000",
                     {m_axi_awvalid, m_axi_wvalid, wait_out, err_irq});
        end
        exp_aw.delete();
        exp_w.delete();
        @(posedge sys_clk);
        #1 sys_nreset = 1'b1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        tick();
        checks++;
        if ({wait_out, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_idle: wait_out/awvalid/wvalid/arvalid=%b expected 0000",
                     {wait_out, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
        end
    endtask

    task automatic test_drain();
        checks++;
        if (exp_aw.size() + exp_w.size() + exp_rsp.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: pending aw=%0d w=%0d rsp=%0d expected 0 0 0",
                     exp_aw.size(), exp_w.size(), exp_rsp.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_half_read();
        test_skewed_handshake();
        test_backpressure();
        test_error();
        test_reset_midflight();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
